rs485_frame_receiver: RTL and testbench



---
 rtl/rs485_frame_receiver.sv | 188 ++++++++++++++++++
 tb/tb_rs485_frame_receiver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs485_frame_receiver.sv
// RS485 slave receiver: oversampled 11-bit deframer with address filter.
// Accepted bytes leave as one-cycle pulses; addr_match gates the replier.
module rs485_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  SLAVE_ADDR   = 8'h01,
  parameter logic [7:0]  BCAST_ADDR   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_is_addr,
  output logic       addr_match,
  output logic       bcast,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    MODE,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          mode_q, mode_n;
  logic          sync1, rx_s;

  logic [7:0]    data_n;
  logic          valid_n, is_addr_n;
  logic          match_n, bcast_n, err_n;
  logic          bit_end;

  assign busy    = (state != IDLE);
  assign bit_end = (cnt == FULL);

  // two-flop synchronizer; idles high so reset never fakes a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      mode_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_is_addr <= 1'b0;
      addr_match <= 1'b0;
      bcast      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      mode_q     <= mode_n;
      rx_data    <= data_n;
      rx_valid   <= valid_n;
      rx_is_addr <= is_addr_n;
      addr_match <= match_n;
      bcast      <= bcast_n;
      frame_err  <= err_n;
    end
  end

  // next-state, bit sampling and address filter
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    mode_n    = mode_q;
    data_n    = rx_data;
    valid_n   = 1'b0;
    is_addr_n = rx_is_addr;
    match_n   = addr_match;
    bcast_n   = bcast;
    err_n     = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n          = '0;
          shift_n[idx]   = rx_s;
          if (idx == 3'd7) begin
            state_n = MODE;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      MODE: begin
        if (bit_end) begin
          cnt_n   = '0;
          mode_n  = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
            if (mode_q) begin
              if (shift == SLAVE_ADDR) begin
                match_n   = 1'b1;
                bcast_n   = 1'b0;
                valid_n   = 1'b1;
                is_addr_n = 1'b1;
                data_n    = shift;
              end else if (shift == BCAST_ADDR) begin
                match_n   = 1'b1;
                bcast_n   = 1'b1;
                valid_n   = 1'b1;
                is_addr_n = 1'b1;
                data_n    = shift;
              end else begin
                match_n = 1'b0;
                bcast_n = 1'b0;
              end
            end else if (addr_match) begin
              valid_n   = 1'b1;
              is_addr_n = 1'b0;
              data_n    = shift;
            end
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rs485_frame_receiver.sv
// Bench for rs485_frame_receiver: directed scenarios plus random frames,
// checked every cycle against a cycle-scheduled behavioural model.
module tb_rs485_frame_receiver;

  localparam int CPB  = 16;
  localparam int MAXC = 20000;
  localparam logic [7:0] SA = 8'h01;
  localparam logic [7:0] BA = 8'hFF;
  // rx driven low on negedge c0: sync at c0+1,c0+2, T0 after c0+3,
  // stop sample in T0+167, outputs seen after edge c0+171
  localparam int LAT = 171;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_is_addr, addr_match, bcast, frame_err, busy;

  rs485_frame_receiver #(
    .CLKS_PER_BIT(CPB),
    .SLAVE_ADDR(SA),
    .BCAST_ADDR(BA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_is_addr(rx_is_addr),
    .addr_match(addr_match),
    .bcast(bcast),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  bit         ev_v[MAXC];
  bit         ev_e[MAXC];
  bit         ev_b[MAXC];
  bit         ev_chg[MAXC];
  bit         ev_rst[MAXC];
  logic [7:0] ev_d[MAXC];
  bit         ev_a[MAXC];
  bit         ev_am[MAXC];
  bit         ev_bc[MAXC];

  bit         m_am = 0, m_bc = 0;
  bit         c_am = 0, c_bc = 0, c_a = 0;
  logic [7:0] c_d = 8'h00;
  int         n_vp = 0, n_ep = 0;
  int         vq[$];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // per-cycle comparison of every output against the model timeline
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (ev_rst[cyc]) begin
        c_am = 0; c_bc = 0; c_d = 8'h00; c_a = 0;
      end
      if (ev_chg[cyc]) begin
        c_am = ev_am[cyc]; c_bc = ev_bc[cyc];
      end
      if (ev_v[cyc]) begin
        c_d = ev_d[cyc]; c_a = ev_a[cyc];
      end
      check("rx_valid", 32'(rx_valid), 32'(ev_v[cyc]));
      check("frame_err", 32'(frame_err), 32'(ev_e[cyc]));
      check("busy", 32'(busy), 32'(ev_b[cyc]));
      check("addr_match", 32'(addr_match), 32'(c_am));
      check("bcast", 32'(bcast), 32'(c_bc));
      check("rx_data", 32'(rx_data), 32'(c_d));
      check("rx_is_addr", 32'(rx_is_addr), 32'(c_a));
      if (rx_valid) begin
        n_vp++;
        vq.push_back(cyc);
      end
      if (frame_err) n_ep++;
    end
  end

  task automatic mark_busy(int a, int b);
    for (int i = a; i <= b; i++)
      if (i >= 0 && i < MAXC) ev_b[i] = 1;
  endtask

  task automatic sched_v(int t, logic [7:0] d, bit a);
    if (t < MAXC) begin
      ev_v[t] = 1; ev_d[t] = d; ev_a[t] = a;
    end
  endtask

  task automatic drive_bit(bit b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // called on a negedge; schedules expectations then drives the frame
  task automatic send_frame(logic [7:0] d, bit mode, bit stop_ok);
    int c0, te;
    c0 = cyc;
    te = c0 + LAT;
    mark_busy(c0 + 3, c0 + LAT - 1);
    if (!stop_ok) begin
      if (te < MAXC) ev_e[te] = 1;
    end else if (mode) begin
      if (d == SA) begin
        sched_v(te, d, 1); m_am = 1; m_bc = 0;
      end else if (d == BA) begin
        sched_v(te, d, 1); m_am = 1; m_bc = 1;
      end else begin
        m_am = 0; m_bc = 0;
      end
      if (te < MAXC) begin
        ev_chg[te] = 1; ev_am[te] = m_am; ev_bc[te] = m_bc;
      end
    end else if (m_am) begin
      sched_v(te, d, 0);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(mode);
    drive_bit(stop_ok);
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, vp0, ep0, g;
    logic [7:0] d;
    bit m, ok;

    repeat (3) @(negedge clk);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset addr_match", 32'(addr_match), 32'd0);
    reset = 1'b0;
    idle(20);

    // 1: own address then data, back to back
    c0 = cyc;
    vq.delete();
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h3F, 1'b0, 1'b1);
    idle(20);
    check("t1 pulses", 32'(vq.size()), 32'd2);
    if (vq.size() >= 2) begin
      check("t1 lat1", 32'(vq[0] - c0), 32'd171);
      check("t1 lat2", 32'(vq[1] - c0), 32'd347);
    end
    check("t1 data", 32'(rx_data), 32'h3F);
    check("t1 is_addr", 32'(rx_is_addr), 32'd0);
    check("t1 match", 32'(addr_match), 32'd1);

    // 2: foreign address drops match, following data ignored
    vp0 = n_vp;
    send_frame(8'h05, 1'b1, 1'b1);
    send_frame(8'h0A, 1'b0, 1'b1);
    idle(20);
    check("t2 match", 32'(addr_match), 32'd0);
    check("t2 pulses", 32'(n_vp - vp0), 32'd0);

    // 3: broadcast address then data
    vp0 = n_vp;
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(20);
    check("t3 match", 32'(addr_match), 32'd1);
    check("t3 bcast", 32'(bcast), 32'd1);
    check("t3 pulses", 32'(n_vp - vp0), 32'd2);
    check("t3 data", 32'(rx_data), 32'h55);

    // 4: bad stop, line held low for 40 bit times
    vp0 = n_vp;
    ep0 = n_ep;
    c0 = cyc;
    mark_busy(c0 + LAT, c0 + 11 * CPB + 40 * CPB + 2);
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    idle(20);
    check("t4 errs", 32'(n_ep - ep0), 32'd1);
    check("t4 pulses", 32'(n_vp - vp0), 32'd0);
    check("t4 busy", 32'(busy), 32'd0);

    // 5: short glitch, then a frame two bit times later
    ep0 = n_ep;
    vp0 = n_vp;
    c0 = cyc;
    mark_busy(c0 + 3, c0 + 3 + CPB / 2 - 1);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(2 * CPB);
    check("t5 glitch pulses", 32'(n_vp - vp0 + n_ep - ep0), 32'd0);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(20);
    check("t5 data", 32'(rx_data), 32'h01);
    check("t5 bcast", 32'(bcast), 32'd0);
    check("t5 pulses", 32'(n_vp - vp0), 32'd1);

    // 6: reset during data bit 4
    vp0 = n_vp;
    c0 = cyc;
    mark_busy(c0 + 3, c0 + 5 * CPB + CPB / 2);
    if (c0 + 5 * CPB + CPB / 2 + 1 < MAXC)
      ev_rst[c0 + 5 * CPB + CPB / 2 + 1] = 1;
    m_am = 0; m_bc = 0;
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 rst busy", 32'(busy), 32'd0);
    check("t6 rst match", 32'(addr_match), 32'd0);
    check("t6 rst data", 32'(rx_data), 32'd0);
    idle(3 * CPB);
    check("t6 aborted", 32'(n_vp - vp0), 32'd0);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h77, 1'b0, 1'b1);
    idle(20);
    check("t6 data", 32'(rx_data), 32'h77);
    check("t6 pulses", 32'(n_vp - vp0), 32'd2);

    // random traffic
    for (int k = 0; k < 30; k++) begin
      if (cyc > MAXC - 1200) break;
      case ($urandom_range(0, 3))
        0: d = SA;
        1: d = BA;
        default: d = 8'($urandom);
      endcase
      m  = 1'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      c0 = cyc;
      if (!ok) mark_busy(c0 + LAT, c0 + 11 * CPB + 2);
      send_frame(d, m, ok);
      g = ok ? $urandom_range(0, 40) : $urandom_range(CPB, 3 * CPB);
      idle(g);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
